// File: rtl/acc_cpu_core.sv
// Parametrised accumulator CPU core: register file, ALU with Z/C flags, conditional jumps,
// halt/resume and run enable. Instruction ROM is external and combinational (count -> instruction).
module acc_cpu_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  localparam int REG_SEL_WIDTH     = $clog2(NUM_REGS),
  localparam int INSTRUCTION_WIDTH = 4 + REG_SEL_WIDTH + DATA_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         resume,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]        count,
  output logic [DATA_WIDTH-1:0]        accumulator,
  output logic                         zeroFlag,
  output logic                         carryFlag,
  output logic                         halted,
  output logic                         illegal,
  input  logic [REG_SEL_WIDTH-1:0]     debugSel,
  output logic [DATA_WIDTH-1:0]        debugData
);

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_LOADI = 4'd1;
  localparam logic [3:0] OP_MOVE  = 4'd2;
  localparam logic [3:0] OP_MOVEA = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JZ    = 4'd10;
  localparam logic [3:0] OP_JC    = 4'd11;
  localparam logic [3:0] OP_HALT  = 4'd12;
  localparam logic [3:0] OP_SRST  = 4'd13;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_count, w_count_nxt, w_count_inc;
  logic [DATA_WIDTH-1:0]   r_acc, w_acc_nxt;
  logic                    r_z, w_z_nxt, r_c, w_c_nxt, r_illegal, w_illegal_nxt;
  logic                    w_reg_we, w_soft_rst, w_acc_wr;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic [3:0]              w_opcode;
  logic [REG_SEL_WIDTH-1:0] w_rsel;
  logic [DATA_WIDTH-1:0]   w_imm, w_operand, w_debug;
  logic [DATA_WIDTH:0]     w_sum, w_diff;

  assign w_opcode    = instruction[INSTRUCTION_WIDTH-1 -: 4];
  assign w_rsel      = instruction[INSTRUCTION_WIDTH-5 -: REG_SEL_WIDTH];
  assign w_imm       = instruction[DATA_WIDTH-1:0];
  assign w_count_inc = r_count + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  // Extra MSB of the widened sum/difference is carry-out / borrow (acc < r).
  assign w_sum       = {1'b0, r_acc} + {1'b0, w_operand};
  assign w_diff      = {1'b0, r_acc} - {1'b0, w_operand};

  // Register-file reads: selects beyond NUM_REGS read as zero.
  always_comb begin
    w_operand = '0;
    w_debug   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_operand = (w_rsel == REG_SEL_WIDTH'(i)) ? r_regs[i] : w_operand;
      w_debug   = (debugSel == REG_SEL_WIDTH'(i)) ? r_regs[i] : w_debug;
    end
  end

  // Next-state and execute logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_acc_nxt     = r_acc;
    w_z_nxt       = r_z;
    w_c_nxt       = r_c;
    w_illegal_nxt = r_illegal;
    w_reg_we      = 1'b0;
    w_soft_rst    = 1'b0;
    w_acc_wr      = 1'b0;
    if (enable) begin
      case (r_state)
        ST_RUN: begin
          w_count_nxt = w_count_inc;
          case (w_opcode)
            OP_NOOP:  begin end
            OP_LOADI: begin w_acc_nxt = w_imm; w_acc_wr = 1'b1; end
            OP_MOVE:  begin w_reg_we = 1'b1; end
            OP_MOVEA: begin w_acc_nxt = w_operand; w_acc_wr = 1'b1; end
            OP_ADD:   begin w_acc_nxt = w_sum[DATA_WIDTH-1:0]; w_c_nxt = w_sum[DATA_WIDTH]; w_acc_wr = 1'b1; end
            OP_SUB:   begin w_acc_nxt = w_diff[DATA_WIDTH-1:0]; w_c_nxt = w_diff[DATA_WIDTH]; w_acc_wr = 1'b1; end
            OP_AND:   begin w_acc_nxt = r_acc & w_operand; w_acc_wr = 1'b1; end
            OP_OR:    begin w_acc_nxt = r_acc | w_operand; w_acc_wr = 1'b1; end
            OP_XOR:   begin w_acc_nxt = r_acc ^ w_operand; w_acc_wr = 1'b1; end
            OP_JMP:   begin w_count_nxt = w_imm[ADDR_WIDTH-1:0]; end
            OP_JZ:    begin w_count_nxt = r_z ? w_imm[ADDR_WIDTH-1:0] : w_count_inc; end
            OP_JC:    begin w_count_nxt = r_c ? w_imm[ADDR_WIDTH-1:0] : w_count_inc; end
            OP_HALT:  begin w_count_nxt = r_count; w_state_nxt = ST_HALT; end
            OP_SRST: begin
              w_soft_rst  = 1'b1;
              w_count_nxt = '0;
              w_acc_nxt   = '0;
              w_z_nxt     = 1'b0;
              w_c_nxt     = 1'b0;
            end
            default:  begin w_illegal_nxt = 1'b1; end
          endcase
          if (w_acc_wr) begin
            w_z_nxt = (w_acc_nxt == '0);
          end else begin
            w_z_nxt = w_z_nxt;
          end
        end
        ST_HALT: begin
          if (resume) begin
            w_count_nxt = w_count_inc;
            w_state_nxt = ST_RUN;
          end else begin
            w_count_nxt = r_count;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_count   <= '0;
      r_acc     <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_acc     <= w_acc_nxt;
      r_z       <= w_z_nxt;
      r_c       <= w_c_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  // Register file: cleared by reset and SRST, written by MOVE.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset || w_soft_rst) begin
        r_regs[i] <= '0;
      end else if (w_reg_we && (w_rsel == REG_SEL_WIDTH'(i))) begin
        r_regs[i] <= r_acc;
      end
    end
  end

  assign count       = r_count;
  assign accumulator = r_acc;
  assign zeroFlag    = r_z;
  assign carryFlag   = r_c;
  assign halted      = (r_state == ST_HALT);
  assign illegal     = r_illegal;
  assign debugData   = w_debug;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed test of acc_cpu_core: instructions are driven directly as the ROM word for each step.
module tb_acc_cpu_core;

  localparam int IW = 14;

  logic          clock = 1'b0;
  logic          reset, enable, resume;
  logic [IW-1:0] instruction;
  logic [7:0]    count, accumulator, debugData;
  logic          zeroFlag, carryFlag, halted, illegal;
  logic [1:0]    debugSel;

  logic          reset4, enable4;
  logic [IW-1:0] instruction4;
  logic [3:0]    count4;
  logic [7:0]    acc4, dbg4;
  logic          z4, c4, h4, ill4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  acc_cpu_core #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(4)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .resume(resume),
    .instruction(instruction), .count(count), .accumulator(accumulator),
    .zeroFlag(zeroFlag), .carryFlag(carryFlag), .halted(halted), .illegal(illegal),
    .debugSel(debugSel), .debugData(debugData)
  );

  acc_cpu_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_REGS(4)) u_dut4 (
    .clock(clock), .reset(reset4), .enable(enable4), .resume(1'b0),
    .instruction(instruction4), .count(count4), .accumulator(acc4),
    .zeroFlag(z4), .carryFlag(c4), .halted(h4), .illegal(ill4),
    .debugSel(2'd0), .debugData(dbg4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic exec(input logic [3:0] op, input logic [1:0] rsel, input logic [7:0] imm);
    instruction = {op, rsel, imm};
    tick(1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; resume = 1'b0; instruction = '0; debugSel = 2'd0;
    reset4 = 1'b1; enable4 = 1'b0; instruction4 = '0;
    tick(2);
    reset = 1'b0; reset4 = 1'b0;
    check("rst_count", count, 0);
    check("rst_acc", accumulator, 0);
    check("rst_z", zeroFlag, 0);
    check("rst_c", carryFlag, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_r0", debugData, 0);

    // LOADI 5; MOVE R1; LOADI 3; ADD R1
    exec(4'd1, 2'd0, 8'h05);
    check("loadi_acc", accumulator, 8'h05);
    exec(4'd2, 2'd1, 8'h00);
    exec(4'd1, 2'd0, 8'h03);
    exec(4'd4, 2'd1, 8'h00);
    check("add_acc", accumulator, 8'h08);
    check("add_z", zeroFlag, 0);
    check("add_c", carryFlag, 0);
    check("add_count", count, 4);
    debugSel = 2'd1; #1;
    check("dbg_r1", debugData, 8'h05);

    // carry-out and zero on wraparound, then JZ taken
    exec(4'd1, 2'd0, 8'hFF);
    exec(4'd2, 2'd0, 8'h00);
    exec(4'd1, 2'd0, 8'h01);
    exec(4'd4, 2'd0, 8'h00);
    check("addc_acc", accumulator, 8'h00);
    check("addc_z", zeroFlag, 1);
    check("addc_c", carryFlag, 1);
    check("addc_count", count, 8);
    exec(4'd10, 2'd0, 8'h20);
    check("jz_taken", count, 8'h20);

    // SUB with borrow, JC taken, JZ not taken
    exec(4'd1, 2'd0, 8'h02);
    exec(4'd2, 2'd2, 8'h00);
    exec(4'd1, 2'd0, 8'h01);
    exec(4'd5, 2'd2, 8'h00);
    check("sub_acc", accumulator, 8'hFF);
    check("sub_c", carryFlag, 1);
    check("sub_z", zeroFlag, 0);
    check("sub_count", count, 8'h24);
    exec(4'd11, 2'd0, 8'h10);
    check("jc_taken", count, 8'h10);
    exec(4'd10, 2'd0, 8'h40);
    check("jz_not_taken", count, 8'h11);

    // logic ops keep C, update Z
    exec(4'd6, 2'd1, 8'h00);
    check("and_acc", accumulator, 8'h05);
    check("and_c_kept", carryFlag, 1);
    exec(4'd8, 2'd1, 8'h00);
    check("xor_acc", accumulator, 8'h00);
    check("xor_z", zeroFlag, 1);
    exec(4'd7, 2'd2, 8'h00);
    check("or_acc", accumulator, 8'h02);
    check("or_z", zeroFlag, 0);
    exec(4'd3, 2'd0, 8'h00);
    check("movea_acc", accumulator, 8'hFF);
    check("movea_count", count, 8'h15);

    // enable low freezes everything, resume lost
    enable = 1'b0; resume = 1'b1; instruction = {4'd2, 2'd1, 8'h00};
    tick(5);
    enable = 1'b1; resume = 1'b0;
    check("en0_count", count, 8'h15);
    check("en0_acc", accumulator, 8'hFF);
    check("en0_z", zeroFlag, 0);
    check("en0_c", carryFlag, 1);
    check("en0_r1", debugData, 8'h05);

    // JMP 7, HALT, hold, resume
    exec(4'd9, 2'd0, 8'h07);
    check("jmp_count", count, 7);
    exec(4'd12, 2'd0, 8'h00);
    check("halt_halted", halted, 1);
    check("halt_count", count, 7);
    instruction = {4'd1, 2'd0, 8'h33};
    tick(10);
    check("halt_hold_count", count, 7);
    check("halt_hold_acc", accumulator, 8'hFF);
    check("halt_hold_halted", halted, 1);
    enable = 1'b0; resume = 1'b1; tick(1);
    enable = 1'b1; resume = 1'b0; tick(1);
    check("resume_lost", halted, 1);
    resume = 1'b1; tick(1); resume = 1'b0;
    check("resume_count", count, 8);
    check("resume_halted", halted, 0);
    tick(1);
    check("post_resume_acc", accumulator, 8'h33);
    check("post_resume_count", count, 9);
    resume = 1'b1;
    exec(4'd0, 2'd0, 8'h00);
    resume = 1'b0;
    check("resume_in_run", count, 8'h0A);

    // illegal opcode, sticky through SRST
    exec(4'd15, 2'd0, 8'h00);
    check("ill_set", illegal, 1);
    check("ill_acc", accumulator, 8'h33);
    check("ill_count", count, 8'h0B);
    exec(4'd13, 2'd0, 8'h00);
    check("srst_count", count, 0);
    check("srst_acc", accumulator, 0);
    check("srst_c", carryFlag, 0);
    check("srst_illegal", illegal, 1);
    check("srst_r1", debugData, 0);

    // reset mid-run and while halted
    exec(4'd1, 2'd0, 8'h09);
    exec(4'd2, 2'd3, 8'h00);
    debugSel = 2'd3; #1;
    check("r3_written", debugData, 8'h09);
    reset = 1'b1;
    exec(4'd1, 2'd0, 8'h77);
    reset = 1'b0;
    check("mrst_count", count, 0);
    check("mrst_acc", accumulator, 0);
    check("mrst_r3", debugData, 0);
    check("mrst_illegal", illegal, 0);
    exec(4'd12, 2'd0, 8'h00);
    check("halt0", halted, 1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check("hrst_halted", halted, 0);
    check("hrst_count", count, 0);
    exec(4'd0, 2'd0, 8'h00);
    check("hrst_restart", count, 1);

    // 4-bit program counter wrap
    enable4 = 1'b1;
    tick(15);
    check("wrap_15", count4, 4'd15);
    tick(1);
    check("wrap_0", count4, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
